// File: rtl/sbmips_stack_if.sv
// Strobe/data bundle between the control unit (master) and the operand stack (slave).
interface sbmips_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic             tos;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             err_ovf;
  logic             err_unf;

  modport master (
    output push, pop, tos, din,
    input  dout, full, empty, count, err_ovf, err_unf
  );

  modport slave (
    input  push, pop, tos, din,
    output dout, full, empty, count, err_ovf, err_unf
  );
endinterface

// File: rtl/sbmips_stack.sv
// Operand stack for the stack-based MIPS datapath: push/pop/tos strobes, registered dout.
// Define SBMIPS_STACK_ERR_EN to build the sticky overflow/underflow flags.
module sbmips_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  sbmips_stack_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             empty, full;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == CW'(DEPTH));
  assign top_idx = AW'(sp_q - 1'b1);
  assign top     = mem[top_idx];

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    sp_d    = sp_q;
    dout_d  = dout_q;
    wr_en   = 1'b0;
    wr_addr = AW'(sp_q);
    if (bus.push && bus.pop) begin
      // Replace top; on an empty stack the pushed word passes straight to dout.
      if (empty) begin
        dout_d = bus.din;
      end else begin
        dout_d  = top;
        wr_en   = 1'b1;
        wr_addr = top_idx;
      end
    end else if (bus.pop) begin
      if (!empty) begin
        dout_d = top;
        sp_d   = sp_q - 1'b1;
      end
    end else begin
      if (bus.tos && !empty) dout_d = top;
      if (bus.push && !full) begin
        wr_en = 1'b1;
        sp_d  = sp_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      sp_q   <= sp_d;
      dout_q <= dout_d;
    end
  end

  // NOTE: storage carries no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_addr] <= bus.din;
  end

  assign bus.dout  = dout_q;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.count = sp_q;

`ifdef SBMIPS_STACK_ERR_EN
  logic err_ovf_q, err_unf_q;
  logic ovf_set, unf_set;

  assign ovf_set = bus.push && !bus.pop && full;
  assign unf_set = !bus.push && (bus.pop || bus.tos) && empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_q | ovf_set;
      err_unf_q <= err_unf_q | unf_set;
    end
  end

  assign bus.err_ovf = err_ovf_q;
  assign bus.err_unf = err_unf_q;
`else
  assign bus.err_ovf = 1'b0;
  assign bus.err_unf = 1'b0;
`endif
endmodule

// File: tb/tb_sbmips_stack.sv
// Self-checking bench for sbmips_stack: queue-based stack model plus a read-data scoreboard.
module tb_sbmips_stack;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;

  sbmips_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sbmips_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] mdl[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] mdl_dout;
  logic             mdl_ovf, mdl_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_status();
    check("count", 32'(bus.count), 32'(mdl.size()));
    check("empty", 32'(bus.empty), 32'(mdl.size() == 0));
    check("full",  32'(bus.full),  32'(mdl.size() == DEPTH));
`ifdef SBMIPS_STACK_ERR_EN
    check("err_ovf", 32'(bus.err_ovf), 32'(mdl_ovf));
    check("err_unf", 32'(bus.err_unf), 32'(mdl_unf));
`else
    check("err_ovf", 32'(bus.err_ovf), 32'd0);
    check("err_unf", 32'(bus.err_unf), 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0; bus.din = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl.delete();
    exp_q.delete();
    mdl_dout = '0;
    mdl_ovf  = 1'b0;
    mdl_unf  = 1'b0;
    check("rst_dout", 32'(bus.dout), 32'd0);
    check_status();
  endtask

  // One cycle of stimulus; model predicts, scoreboard holds the expected read word.
  task automatic step(input logic p, input logic po, input logic t, input logic [WIDTH-1:0] d,
                      input bit full_chk = 1'b0);
    logic rd = 1'b0;
    logic [WIDTH-1:0] rv = '0;
    bit   was_empty = (mdl.size() == 0);
    bit   was_full  = (mdl.size() == DEPTH);
    if (p && po) begin
      rd = 1'b1;
      if (was_empty) rv = d;
      else begin rv = mdl[mdl.size()-1]; mdl[mdl.size()-1] = d; end
    end else if (po) begin
      if (!was_empty) begin rd = 1'b1; rv = mdl.pop_back(); end
      else mdl_unf = 1'b1;
    end else begin
      if (t) begin
        if (!was_empty) begin rd = 1'b1; rv = mdl[mdl.size()-1]; end
        else if (!p) mdl_unf = 1'b1;
      end
      if (p) begin
        if (!was_full) mdl.push_back(d);
        else mdl_ovf = 1'b1;
      end
    end
    if (rd) begin exp_q.push_back(rv); mdl_dout = rv; end

    bus.push = p; bus.pop = po; bus.tos = t; bus.din = d;
    @(posedge clk); #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0;

    if (exp_q.size() > 0) check("rd_data", 32'(bus.dout), 32'(exp_q.pop_front()));
    else check("dout_hold", 32'(bus.dout), 32'(mdl_dout));
    if (full_chk) check_status();
    else check("count", 32'(bus.count), 32'(mdl.size()));
  endtask

  initial begin
    do_reset();

    // LIFO order
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    step(1, 0, 0, 8'h33, 1'b1);
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    step(0, 1, 0, '0, 1'b1);

    // Fill to DEPTH, then overflow push is dropped
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, WIDTH'(8'h40 + i));
    check_status();
    step(1, 0, 0, 8'hAA, 1'b1);
    step(1, 1, 0, 8'h9E, 1'b1);        // replace top while full: no overflow
    step(1, 0, 1, 8'hAB, 1'b1);        // push+tos while full: read only
    step(0, 1, 0, '0, 1'b1);
    while (mdl.size() > 0) step(0, 1, 0, '0);

    // Underflow on empty: pop, tos, pop+tos all leave dout held
    step(0, 1, 0, '0, 1'b1);
    step(0, 0, 1, '0, 1'b1);
    step(0, 1, 1, '0, 1'b1);
    step(1, 0, 1, 8'h5A, 1'b1);        // push+tos on empty: push only
    step(0, 0, 1, '0, 1'b1);

    // Replace-top and tos
    do_reset();
    step(1, 0, 0, 8'h05);
    step(1, 1, 0, 8'h77, 1'b1);
    step(0, 0, 1, '0, 1'b1);
    step(1, 0, 1, 8'h66, 1'b1);
    step(0, 1, 1, '0, 1'b1);

    // Pass-through on empty, then reset mid-sequence
    do_reset();
    step(1, 1, 0, 8'h3C, 1'b1);
    step(1, 0, 0, 8'h01);
    step(1, 0, 0, 8'h02);
    step(1, 0, 0, 8'h03);
    do_reset();
    step(0, 0, 1, '0, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0] s = 3'($urandom_range(7));
      step(s[0] | (i % 5 == 0), s[1], s[2], WIDTH'($urandom), (i % 8 == 0));
    end
    check_status();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
